bus_memory: RTL and testbench
=============================

// Module: bus_memory
// PURPOSE
//  Parametrised, synthesizable main-memory bus slave for CPU_top's request/DV bus. Successor to the fixed mainMemory model.
//  Adds configurable depth, base address, wait states and init file; RISC-V byte/half/word access with sign/zero extension.
//  Adds misalignment/range error reporting and a release handshake.
//  Sits between CPU_top's o_bus_* outputs and its i_bus_* inputs, in both the benches and the FPGA top.
// PARAMETERS
//  DEPTH_WORDS  4096          number of 32-bit words; power of two
//  BASE_ADDR    32'h0000_0000 byte address of word 0; DEPTH_WORDS*4-aligned
//  LATENCY      2             wait states, 0..15, inserted before the response
//  INIT_FILE    ""            $readmemh image loaded at elaboration when non-empty
// PORTS
//  i_clk             in   1   clock, all logic on rising edge
//  i_rst             in   1   synchronous reset, active-high
//  i_bus_DV          in   1   request; level, held by master until it sees o_bus_DV
//  i_bus_address     in   32  byte address
//  i_bus_data        in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  i_bhw             in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
//  i_write_notread   in   1   1 = store, 0 = load
//  o_bus_data        out  32  load data, extended per i_bhw; valid only while o_bus_DV
//  o_bus_DV          out  1   one-cycle response strobe
//  o_error           out  1   qualifies o_bus_DV: access was rejected
// BEHAVIOUR
//  Reset
//   - i_rst at an edge: state=IDLE, wait counter=0, o_bus_DV=0, o_error=0, o_bus_data=0.
//   - Memory array is not cleared by reset.
//   - Reset mid-transaction abandons it. A store not yet committed is never written.
//  States: IDLE -> BUSY -> ACK -> RELEASE -> IDLE
//   - IDLE: at an edge with i_bus_DV=1, latch address, data, bhw and write_notread.
//     Go to BUSY with counter=LATENCY, or straight to ACK when LATENCY=0.
//   - BUSY: counter decrements each cycle. At counter==1 go to ACK.
//     Master changes to the bus inputs during BUSY are ignored; latched values are used.
//   - ACK: o_bus_DV=1 for exactly one cycle, o_error valid. Next state is RELEASE.
//   - RELEASE: wait for i_bus_DV=0, then IDLE. A request still high here is not a new request.
//  Latency
//   - o_bus_DV is high in the cycle LATENCY+1 edges after the sampling edge.
//   - Minimum request-to-request spacing is LATENCY+3 cycles.
//  Access rules (little-endian)
//   - offset = address - BASE_ADDR; word index = offset[log2(DEPTH_WORDS)+1:2].
//   - B/BU use any byte lane; H/HU need address[0]=0 and use lane address[1]; W needs address[1:0]=0.
//   - Load: the selected lane is sign-extended (B, H) or zero-extended (BU, HU).
//   - Store: only the addressed byte lanes are written; bhw 100/101 on a store are illegal.
//   - The store commits at the edge entering ACK.
//   - The load is read from memory at the same edge, so it sees any earlier committed store.
//  Errors
//   - o_error=1 with o_bus_DV when: misaligned, illegal bhw, or offset >= DEPTH_WORDS*4 (including below base).
//   - On error: no memory write, o_bus_data=0, and the full handshake still completes.
//  Outputs
//   - o_bus_data and o_error are registered. When o_bus_DV=0 they are 0.
// TESTING
//  1 Reset/idle:
//    - i_rst high 3 cycles, i_bus_DV=0 -> o_bus_DV=0, o_error=0, o_bus_data=0 throughout.
//  2 Word round trip, LATENCY=2:
//    - SW 0xDEADBEEF @0x100 -> DV exactly 3 cycles after the sampling edge, o_error=0.
//    - LW @0x100 -> o_bus_data=0xDEADBEEF.
//  3 Byte/half extension:
//    - SB 0x80 @0x201 over word 0x11223344 -> word reads 0x11228044.
//    - LB @0x201 = 0xFFFFFF80; LBU @0x201 = 0x00000080.
//    - LH @0x202 = 0x00001122; LHU @0x200 = 0x00008044.
//  4 Errors:
//    - LW @0x102 -> o_error=1, data=0.
//    - SH @0x103 -> o_error=1, memory unchanged.
//    - LW @BASE_ADDR+DEPTH_WORDS*4 -> o_error=1.
//    - bhw=011 -> o_error=1.
//  5 Handshake:
//    - master holds i_bus_DV high 5 cycles after DV -> only one DV pulse.
//    - bus input changes during BUSY are ignored.
//    - LATENCY=0 -> DV 1 cycle after sampling.
//  6 Reset mid-op:
//    - SW 0xCAFEF00D @0x40, i_rst asserted during BUSY -> no DV.
//    - LW @0x40 after reset -> old value returned.

Source files
------------

// File: rtl/bus_memory.sv
// Word-organised RAM slave on the request/DV bus with RISC-V byte/half/word access and error reporting.
// Response strobe LATENCY+1 edges after the request is sampled; a request still held after the response waits in RELEASE.
module bus_memory #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_DV,
    input  logic [31:0] i_bus_address,
    input  logic [31:0] i_bus_data,
    input  logic [2:0]  i_bhw,
    input  logic        i_write_notread,
    output logic [31:0] o_bus_data,
    output logic        o_bus_DV,
    output logic        o_error
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam bit          ZERO_LAT  = (LATENCY == 0);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK, S_RELEASE} state_t;

    logic [31:0] mem_q [DEPTH_WORDS];

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q, wdat_q, res_dat_q, dat_q;
    logic [2:0]  bhw_q;
    logic        we_q, res_err_q, dv_q, err_q;

    logic [31:0] req_addr, req_dat, offset, rd_word, load_dat, wr_word;
    logic [2:0]  req_bhw;
    logic        req_we, bad, acc_err, enter_ack, commit;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [AW-1:0] idx;

    // In IDLE the live bus is decoded so a zero-latency access can complete at the sampling edge.
    always_comb begin
        req_addr = (state_q == S_IDLE) ? i_bus_address   : addr_q;
        req_dat  = (state_q == S_IDLE) ? i_bus_data      : wdat_q;
        req_bhw  = (state_q == S_IDLE) ? i_bhw           : bhw_q;
        req_we   = (state_q == S_IDLE) ? i_write_notread : we_q;
        offset   = req_addr - BASE_ADDR;
        idx      = offset[AW+1:2];
        rd_word  = mem_q[idx];
        lane_b   = rd_word[{req_addr[1:0], 3'b000} +: 8];
        lane_h   = rd_word[{req_addr[1], 4'b0000} +: 16];

        case (req_bhw)
            3'b000:  bad = 1'b0;
            3'b100:  bad = req_we;
            3'b001:  bad = req_addr[0];
            3'b101:  bad = req_we | req_addr[0];
            3'b010:  bad = |req_addr[1:0];
            default: bad = 1'b1;
        endcase
        acc_err = bad | ({1'b0, offset} >= SPAN);

        case (req_bhw)
            3'b000:  load_dat = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_dat = {24'd0, lane_b};
            3'b001:  load_dat = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_dat = {16'd0, lane_h};
            3'b010:  load_dat = rd_word;
            default: load_dat = 32'd0;
        endcase

        wr_word = rd_word;
        case (req_bhw[1:0])
            2'b00:   wr_word[{req_addr[1:0], 3'b000} +: 8] = req_dat[7:0];
            2'b01:   wr_word[{req_addr[1], 4'b0000} +: 16] = req_dat[15:0];
            default: wr_word = req_dat;
        endcase

        enter_ack = ((state_q == S_IDLE) && i_bus_DV && ZERO_LAT) ||
                    ((state_q == S_BUSY) && (cnt_q == 4'd1));
        commit    = enter_ack && req_we && !acc_err && !i_rst;
    end

    always_ff @(posedge i_clk) begin
        if (commit) begin
            mem_q[idx] <= wr_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 32'd0;
            wdat_q    <= 32'd0;
            bhw_q     <= 3'd0;
            we_q      <= 1'b0;
            res_dat_q <= 32'd0;
            res_err_q <= 1'b0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= 32'd0;
        end else begin
            dv_q  <= 1'b0;
            err_q <= 1'b0;
            dat_q <= 32'd0;
            if (enter_ack) begin
                res_err_q <= acc_err;
                res_dat_q <= (acc_err || req_we) ? 32'd0 : load_dat;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_bus_DV) begin
                        addr_q <= i_bus_address;
                        wdat_q <= i_bus_data;
                        bhw_q  <= i_bhw;
                        we_q   <= i_write_notread;
                        if (ZERO_LAT) begin
                            state_q <= S_ACK;
                        end else begin
                            state_q <= S_BUSY;
                            cnt_q   <= 4'(LATENCY);
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= S_ACK;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    dv_q    <= 1'b1;
                    err_q   <= res_err_q;
                    dat_q   <= res_dat_q;
                    state_q <= S_RELEASE;
                end
                default: begin
                    // A request still held here belongs to the transaction just answered.
                    if (!i_bus_DV) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_bus_DV   = dv_q;
    assign o_error    = err_q;
    assign o_bus_data = dat_q;
endmodule

// File: tb/tb_bus_memory.sv
// Two instances: A (1024 words, base 0, 2 wait states) and B (256 words, base 0x1000, no wait states).
module tb_bus_memory;
    logic        clk = 1'b0;
    logic        rst;
    logic        dv_i   [2];
    logic [31:0] addr_i [2];
    logic [31:0] wdat_i [2];
    logic [2:0]  bhw_i  [2];
    logic        we_i   [2];
    logic [31:0] rdat_o [2];
    logic        dv_o   [2];
    logic        err_o  [2];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mem_m0 [int unsigned];
    logic [7:0] mem_m1 [int unsigned];

    always #5 clk = ~clk;

    bus_memory #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(2), .INIT_FILE("")) u_a (
        .i_clk(clk), .i_rst(rst), .i_bus_DV(dv_i[0]), .i_bus_address(addr_i[0]),
        .i_bus_data(wdat_i[0]), .i_bhw(bhw_i[0]), .i_write_notread(we_i[0]),
        .o_bus_data(rdat_o[0]), .o_bus_DV(dv_o[0]), .o_error(err_o[0]));

    bus_memory #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_1000), .LATENCY(0), .INIT_FILE("")) u_b (
        .i_clk(clk), .i_rst(rst), .i_bus_DV(dv_i[1]), .i_bus_address(addr_i[1]),
        .i_bus_data(wdat_i[1]), .i_bhw(bhw_i[1]), .i_write_notread(we_i[1]),
        .o_bus_data(rdat_o[1]), .o_bus_DV(dv_o[1]), .o_error(err_o[1]));

    // Byte-addressed reference: size from funct3, alignment by modulo, range from base/span.
    function automatic void model_access(input bit b, input bit we, input logic [31:0] addr,
                                         input logic [31:0] data, input logic [2:0] bhw,
                                         output logic [31:0] rd, output bit er);
        logic [31:0] base, span, off;
        int n;
        logic [7:0] by;
        base = b ? 32'h1000 : 32'h0;
        span = b ? 32'd1024 : 32'd4096;
        case (bhw)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        off = addr - base;
        rd  = 32'd0;
        if (n == 0)                er = 1'b1;
        else if (we && bhw >= 3'd4) er = 1'b1;
        else if (addr % n != 0)    er = 1'b1;
        else if (off >= span)      er = 1'b1;
        else                       er = 1'b0;
        if (!er) begin
            for (int i = 0; i < n; i++) begin
                if (we) begin
                    if (b) mem_m1[addr + i] = data[8*i +: 8];
                    else   mem_m0[addr + i] = data[8*i +: 8];
                end else begin
                    by = 8'd0;
                    if (b && mem_m1.exists(addr + i))  by = mem_m1[addr + i];
                    if (!b && mem_m0.exists(addr + i)) by = mem_m0[addr + i];
                    rd = rd | (32'(by) << (8*i));
                end
            end
            if (!we && n < 4 && bhw < 3'd4 && rd[8*n-1])
                rd = rd | ~((32'd1 << (8*n)) - 32'd1);
        end
    endfunction

    task automatic do_txn(input bit b, input bit we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] bhw, input int hold, input bit scramble,
                          output logic [31:0] rd, output logic er, output int lat, output int npulse,
                          output bit clean, output logic [31:0] m_rd, output bit m_er);
        bit got;
        model_access(b, we, addr, data, bhw, m_rd, m_er);
        @(negedge clk);
        dv_i[b] = 1'b1; addr_i[b] = addr; wdat_i[b] = data; bhw_i[b] = bhw; we_i[b] = we;
        lat = 0; got = 1'b0; clean = 1'b1; rd = 32'd0; er = 1'b0; npulse = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            if (dv_o[b]) begin
                got = 1'b1; rd = rdat_o[b]; er = err_o[b]; npulse = 1;
            end else begin
                if (rdat_o[b] !== 32'd0 || err_o[b] !== 1'b0) clean = 1'b0;
                lat++;
                if (scramble && lat == 1) begin
                    addr_i[b] = addr ^ 32'h0000_0F04; wdat_i[b] = $urandom;
                    bhw_i[b] = 3'b011; we_i[b] = ~we;
                end
            end
        end
        if (!got) lat = -1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (dv_o[b]) npulse++;
        end
        dv_i[b] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (dv_o[b]) npulse++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int b = 0; b < 2; b++) begin
                n_cmp++;
                if ({dv_o[b], err_o[b], rdat_o[b]} !== 34'd0) begin
                    n_fail++;
                    $display("FAIL reset_outputs inst%0d cyc%0d: got dv=%b err=%b data=%h want all 0",
                             b, c, dv_o[b], err_o[b], rdat_o[b]);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_round_trip();
        logic [31:0] rd, mrd; logic er; bit mer, clean; int lat, np;
        do_txn(0, 1, 32'h100, 32'hDEAD_BEEF, 3'b010, 0, 0, rd, er, lat, np, clean, mrd, mer);
        n_cmp++;
        if (lat !== 3) begin n_fail++; $display("FAIL sw_latency: got %0d want 3", lat); end
        n_cmp++;
        if (er !== 1'b0 || np !== 1 || !clean) begin
            n_fail++; $display("FAIL sw_response: got err=%b pulses=%0d clean=%b want 0/1/1", er, np, clean);
        end
        do_txn(0, 0, 32'h100, 32'h0, 3'b010, 0, 0, rd, er, lat, np, clean, mrd, mer);
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            n_fail++; $display("FAIL lw_0x100: got %h err=%b want deadbeef err=0", rd, er);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd, mrd; logic er; bit mer, clean; int lat, np;
        logic [31:0] exp_v [5];
        logic [31:0] a_v [5];
        logic [2:0]  f_v [5];
        exp_v = '{32'h1122_8044, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1122, 32'h0000_8044};
        a_v   = '{32'h200, 32'h201, 32'h201, 32'h202, 32'h200};
        f_v   = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
        do_txn(0, 1, 32'h200, 32'h1122_3344, 3'b010, 0, 0, rd, er, lat, np, clean, mrd, mer);
        do_txn(0, 1, 32'h201, 32'hFFFF_FF80, 3'b000, 0, 0, rd, er, lat, np, clean, mrd, mer);
        n_cmp++;
        if (er !== 1'b0) begin n_fail++; $display("FAIL sb_0x201_err: got %b want 0", er); end
        for (int i = 0; i < 5; i++) begin
            do_txn(0, 0, a_v[i], 32'h0, f_v[i], 0, 0, rd, er, lat, np, clean, mrd, mer);
            n_cmp++;
            if (rd !== exp_v[i] || er !== 1'b0) begin
                n_fail++;
                $display("FAIL extend_%0d f3=%b @%h: got %h err=%b want %h", i, f_v[i], a_v[i], rd, er, exp_v[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, mrd; logic er; bit mer, clean; int lat, np;
        logic [31:0] a_v [5];
        logic [2:0]  f_v [5];
        bit          w_v [5];
        a_v = '{32'h102, 32'h103, 32'h1000, 32'h100, 32'h100};
        f_v = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
        w_v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            do_txn(0, w_v[i], a_v[i], 32'h5555_AAAA, f_v[i], 0, 0, rd, er, lat, np, clean, mrd, mer);
            n_cmp++;
            if (er !== 1'b1 || rd !== 32'd0 || np !== 1 || lat !== 3) begin
                n_fail++;
                $display("FAIL error_%0d @%h f3=%b: got err=%b data=%h pulses=%0d lat=%0d want 1/0/1/3",
                         i, a_v[i], f_v[i], er, rd, np, lat);
            end
        end
        do_txn(0, 0, 32'h100, 32'h0, 3'b010, 0, 0, rd, er, lat, np, clean, mrd, mer);
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL err_no_write: got %h want deadbeef", rd); end
    endtask

    task automatic test_handshake();
        logic [31:0] rd, mrd; logic er; bit mer, clean; int lat, np;
        do_txn(0, 0, 32'h100, 32'h0, 3'b010, 5, 0, rd, er, lat, np, clean, mrd, mer);
        n_cmp++;
        if (np !== 1 || rd !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL held_request: got pulses=%0d data=%h want 1 deadbeef", np, rd);
        end
        do_txn(0, 0, 32'h100, 32'h0, 3'b010, 0, 1, rd, er, lat, np, clean, mrd, mer);
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat !== 3) begin
            n_fail++; $display("FAIL busy_ignore: got %h err=%b lat=%0d want deadbeef 0 3", rd, er, lat);
        end
        do_txn(1, 1, 32'h1010, 32'h5A5A_1234, 3'b010, 0, 0, rd, er, lat, np, clean, mrd, mer);
        n_cmp++;
        if (lat !== 1 || er !== 1'b0 || np !== 1) begin
            n_fail++; $display("FAIL lat0_store: got lat=%0d err=%b pulses=%0d want 1 0 1", lat, er, np);
        end
        do_txn(1, 0, 32'h1010, 32'h0, 3'b010, 0, 0, rd, er, lat, np, clean, mrd, mer);
        n_cmp++;
        if (lat !== 1 || rd !== 32'h5A5A_1234) begin
            n_fail++; $display("FAIL lat0_load: got lat=%0d data=%h want 1 5a5a1234", lat, rd);
        end
        do_txn(1, 0, 32'h0FFC, 32'h0, 3'b010, 0, 0, rd, er, lat, np, clean, mrd, mer);
        n_cmp++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            n_fail++; $display("FAIL below_base: got err=%b data=%h want 1 0", er, rd);
        end
        do_txn(1, 0, 32'h1400, 32'h0, 3'b010, 0, 0, rd, er, lat, np, clean, mrd, mer);
        n_cmp++;
        if (er !== 1'b1) begin n_fail++; $display("FAIL above_top_b: got err=%b want 1", er); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd, mrd; logic er; bit mer, clean; int lat, np;
        bit seen;
        do_txn(0, 1, 32'h40, 32'h1234_5678, 3'b010, 0, 0, rd, er, lat, np, clean, mrd, mer);
        @(negedge clk);
        dv_i[0] = 1'b1; addr_i[0] = 32'h40; wdat_i[0] = 32'hCAFE_F00D; bhw_i[0] = 3'b010; we_i[0] = 1'b1;
        seen = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (dv_o[0]) seen = 1'b1; end
        dv_i[0] = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (dv_o[0]) seen = 1'b1; end
        n_cmp++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL midop_no_dv: got dv seen=%b want 0", seen); end
        do_txn(0, 0, 32'h40, 32'h0, 3'b010, 0, 0, rd, er, lat, np, clean, mrd, mer);
        n_cmp++;
        if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL midop_old_value: got %h want 12345678", rd); end
    endtask

    task automatic test_random(input bit b, input int n_ops);
        logic [31:0] rd, mrd, base, addr; logic er; bit mer, clean; int lat, np;
        logic [2:0] f3;
        bit we;
        base = b ? 32'h1040 : 32'h300;
        for (int w = 0; w < 16; w++)
            do_txn(b, 1, base + 32'(4*w), $urandom, 3'b010, 0, 0, rd, er, lat, np, clean, mrd, mer);
        for (int k = 0; k < n_ops; k++) begin
            addr = base + $urandom_range(0, 63);
            if ($urandom_range(0, 9) == 0) addr = b ? 32'h0FC0 + $urandom_range(0, 63) : 32'h1000 + $urandom_range(0, 255);
            case ($urandom_range(0, 9))
                0, 1:    f3 = 3'b000;
                2:       f3 = 3'b100;
                3, 4:    f3 = 3'b001;
                5:       f3 = 3'b101;
                6, 7:    f3 = 3'b010;
                default: f3 = 3'($urandom_range(3, 7));
            endcase
            we = ($urandom_range(0, 2) == 0);
            do_txn(b, we, addr, $urandom, f3, 0, 0, rd, er, lat, np, clean, mrd, mer);
            n_cmp++;
            if (er !== mer || lat !== (b ? 1 : 3) || np !== 1 || !clean || (!we && rd !== mrd)) begin
                n_fail++;
                $display("FAIL random_i%0d_%0d we=%b f3=%b @%h: got data=%h err=%b lat=%0d pulses=%0d clean=%b want data=%h err=%b",
                         b, k, we, f3, addr, rd, er, lat, np, clean, mrd, mer);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int b = 0; b < 2; b++) begin
            dv_i[b] = 1'b0; addr_i[b] = 32'd0; wdat_i[b] = 32'd0; bhw_i[b] = 3'd0; we_i[b] = 1'b0;
        end
        test_reset();
        test_word_round_trip();
        test_byte_half();
        test_errors();
        test_handshake();
        test_reset_midop();
        test_random(0, 80);
        test_random(1, 30);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
